// File: rtl/sequence_loader.sv
// Instruction memory fed by a byte-stream loader: packs 15 host bytes MSB-first
// into 120-bit words and serves the decoder through a registered read port.
module sequence_loader #(
    parameter int ADDR_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [63:0]          flg,
    output logic [3:0]           op_code,
    output logic [19:0]          data,
    output logic [31:0]          time_arg,
    output logic [ADDR_SIZE:0]   word_count,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [111:0]         shift_q, shift_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [ADDR_SIZE:0]   word_count_q, word_count_d;
    logic                 load_err_q, load_err_d;
    logic [119:0]         rd_word_q;
    logic [119:0]         mem_q [DEPTH];

    logic                 accept;
    logic                 mem_full;
    logic                 wr_en;
    logic [119:0]         wr_word;

    // word_count never exceeds DEPTH, so its MSB alone flags a full memory.
    assign mem_full = word_count_q[ADDR_SIZE];
    assign accept   = rx_valid & rx_ready;
    assign wr_word  = {shift_q, rx_data};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_count_q <= '0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            word_count_q <= word_count_d;
            load_err_q   <= load_err_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        word_count_d = word_count_q;
        load_err_d   = load_err_q;
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    state_d      = S_LOAD;
                    byte_cnt_d   = '0;
                    word_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (!load_en) begin
                    state_d = S_FINISH;
                end else if (accept) begin
                    if (mem_full) begin
                        load_err_d = 1'b1;
                    end else if (byte_cnt_q == 4'd14) begin
                        byte_cnt_d   = '0;
                        word_count_d = word_count_q + (ADDR_SIZE + 1)'(1);
                    end else begin
                        shift_d    = {shift_q[103:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (byte_cnt_q != 4'd0) begin
                    load_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = (state_q == S_LOAD) && load_en;
        load_done = (state_q == S_FINISH) && (byte_cnt_q == 4'd0) && !load_err_q;
        wr_en     = accept && !mem_full && (byte_cnt_q == 4'd14);
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; contents
    // survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_count_q[ADDR_SIZE-1:0]] <= wr_word;
        end
    end

    // Sampling the array here, in the same edge as the write, gives read-first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_word_q <= '0;
        end else begin
            rd_word_q <= mem_q[rd_addr];
        end
    end

    assign flg        = rd_word_q[119:56];
    assign op_code    = rd_word_q[55:52];
    assign data       = rd_word_q[51:32];
    assign time_arg   = rd_word_q[31:0];
    assign word_count = word_count_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_sequence_loader.sv
// Directed bench for sequence_loader built with a 4-word memory so the
// overflow path is reachable; expected words are constants built in the bench.
module tb_sequence_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] rd_addr;
    logic [63:0]   flg;
    logic [3:0]    op_code;
    logic [19:0]   data;
    logic [31:0]   time_arg;
    logic [AW:0]   word_count;
    logic          load_done;
    logic          load_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [119:0] wa, wb, wp, wq0, wq1, wx, wy;
    logic [119:0] w2 [4];
    logic [119:0] w4 [5];

    sequence_loader #(.ADDR_SIZE(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rd_addr    (rd_addr),
        .flg        (flg),
        .op_code    (op_code),
        .data       (data),
        .time_arg   (time_arg),
        .word_count (word_count),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [119:0] mk(input logic [63:0] f, input logic [3:0] o,
                                        input logic [19:0] d, input logic [31:0] t);
        return {f, o, d, t};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the next negedge after the byte's posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            check("rdy_gap", 128'(rx_ready), 128'(1));
        end
        rx_valid = 1'b1;
        rx_data  = b;
        check("rdy", 128'(rx_ready), 128'(1));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [119:0] w, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send_byte(w[119-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic start_session();
        load_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_session(input string tag, input int exp_wc, input logic exp_done,
                               input logic exp_err);
        load_en = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 128'(load_done), 128'(exp_done));
        check({tag, "_rdy_fin"}, 128'(rx_ready), 128'(0));
        @(negedge clk);
        check({tag, "_done_off"}, 128'(load_done), 128'(0));
        check({tag, "_wc"}, 128'(word_count), 128'(exp_wc));
        check({tag, "_err"}, 128'(load_err), 128'(exp_err));
    endtask

    task automatic read_word(input string tag, input logic [AW-1:0] a, input logic [119:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, 128'({flg, op_code, data, time_arg}), 128'(exp));
    endtask

    initial begin
        wa    = mk(64'h1, 4'd2, 20'd20, 32'd0);
        wb    = mk(64'h0, 4'd3, 20'd2, 32'd0);
        w2[0] = mk(64'hDEADBEEF_01234567, 4'hA, 20'h12345, 32'hCAFEF00D);
        w2[1] = mk(64'hFFFF0000_FFFF0000, 4'h5, 20'hABCDE, 32'h00000001);
        w2[2] = mk(64'h80000000_00000001, 4'hF, 20'hFFFFF, 32'hFFFFFFFF);
        w2[3] = mk(64'h01234567_89ABCDEF, 4'h0, 20'h00001, 32'h80000000);
        wp    = mk(64'h55555555_55555555, 4'h3, 20'h55555, 32'hAAAAAAAA);
        w4[0] = mk(64'h10, 4'h1, 20'h11, 32'h12);
        w4[1] = mk(64'h20, 4'h2, 20'h21, 32'h22);
        w4[2] = mk(64'h30, 4'h3, 20'h31, 32'h32);
        w4[3] = mk(64'h40, 4'h4, 20'h41, 32'h42);
        w4[4] = mk(64'h50, 4'h5, 20'h51, 32'h52);
        wq0   = mk(64'h77777777_77777777, 4'h7, 20'h77777, 32'h77777777);
        wq1   = mk(64'h99999999_99999999, 4'h9, 20'h99999, 32'h99999999);
        wx    = mk(64'hABCD, 4'h9, 20'h9, 32'h9);
        wy    = mk(64'h1234, 4'h6, 20'h66, 32'h66);

        reset    = 1'b0;
        load_en  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rd_addr  = '0;
        #3;
        check("rst_rdy", 128'(rx_ready), 128'(0));
        check("rst_wc", 128'(word_count), 128'(0));
        check("rst_done", 128'(load_done), 128'(0));
        check("rst_err", 128'(load_err), 128'(0));
        check("rst_rd", 128'({flg, op_code, data, time_arg}), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Two back-to-back words, clean close.
        start_session();
        send_bytes(wa, 15, 0);
        send_bytes(wb, 15, 0);
        end_session("t1", 2, 1'b1, 1'b0);
        read_word("t1_rd1", 2'd1, wb);
        read_word("t1_rd0", 2'd0, wa);

        // Four words with random valid gaps; ready must hold through the gaps.
        start_session();
        for (int k = 0; k < 4; k++) send_bytes(w2[k], 15, 5);
        end_session("t2", 4, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) read_word("t2_rd", AW'(k), w2[k]);

        // 20 bytes: one word plus a discarded partial.
        start_session();
        send_bytes(wp, 15, 0);
        send_bytes(w2[3], 5, 0);
        end_session("t3", 1, 1'b0, 1'b1);
        read_word("t3_rd0", 2'd0, wp);
        read_word("t3_rd1", 2'd1, w2[1]);

        // Five words into a four-word memory.
        start_session();
        for (int k = 0; k < 5; k++) send_bytes(w4[k], 15, 0);
        end_session("t4", 4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) read_word("t4_rd", AW'(k), w4[k]);

        // Reset after byte 7 of the second word.
        start_session();
        send_bytes(wq0, 15, 0);
        send_bytes(wq1, 7, 0);
        check("t5_wc_pre", 128'(word_count), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("t5_rdy", 128'(rx_ready), 128'(0));
        check("t5_wc", 128'(word_count), 128'(0));
        check("t5_done", 128'(load_done), 128'(0));
        check("t5_err", 128'(load_err), 128'(0));
        check("t5_rd", 128'({flg, op_code, data, time_arg}), 128'(0));
        load_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_word("t5_old0", 2'd0, wq0);
        start_session();
        send_bytes(wx, 15, 0);
        end_session("t5", 1, 1'b1, 1'b0);
        read_word("t5_new0", 2'd0, wx);
        read_word("t5_keep1", 2'd1, w4[1]);

        // Read the address being written in the commit cycle: read-first.
        start_session();
        send_bytes(wy, 14, 0);
        rd_addr = 2'd0;
        send_byte(wy[7:0], 0);
        check("t6_old", 128'({flg, op_code, data, time_arg}), 128'(wx));
        @(negedge clk);
        check("t6_new", 128'({flg, op_code, data, time_arg}), 128'(wy));
        end_session("t6", 1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
